// File: rtl/counter_sequencer.sv
// rtl/counter_sequencer.sv - modulo-N count sequencer: run/pause/stop/repeat FSM over a WIDTH-bit counter
module counter_sequencer #(
    parameter int WIDTH = 5,
    parameter int REP_W = 4
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_mod,
    input  logic [REP_W-1:0] cfg_reps,
    input  logic             cfg_down,
    input  logic             start,
    input  logic             pause,
    input  logic             stop,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             done,
    output logic             busy,
    output logic [1:0]       state,
    output logic [REP_W-1:0] rep_left
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           st_q, st_d;
    logic [WIDTH-1:0] count_d;
    logic [REP_W-1:0] rep_d;

    // Stored config is what the host wrote; run config is frozen at start so
    // a write in the same cycle as start only affects the following run.
    logic [WIDTH-1:0] mod_q, run_mod_q, run_mod_d;
    logic [REP_W-1:0] reps_q;
    logic             down_q, run_down_q, run_down_d;

    logic [WIDTH-1:0] term_v, first_v, idle_first_v;

    // A modulus of 0 means 2^WIDTH, which falls out of WIDTH-bit wraparound.
    assign term_v       = run_down_q ? '0 : run_mod_q - WIDTH'(1);
    assign first_v      = run_down_q ? run_mod_q - WIDTH'(1) : '0;
    assign idle_first_v = down_q ? mod_q - WIDTH'(1) : '0;

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            st_q       <= IDLE;
            count      <= '0;
            rep_left   <= '0;
            mod_q      <= '0;
            reps_q     <= '0;
            down_q     <= 1'b0;
            run_mod_q  <= '0;
            run_down_q <= 1'b0;
        end else begin
            st_q       <= st_d;
            count      <= count_d;
            rep_left   <= rep_d;
            run_mod_q  <= run_mod_d;
            run_down_q <= run_down_d;
            if (st_q == IDLE && cfg_valid) begin
                mod_q  <= cfg_mod;
                reps_q <= cfg_reps;
                down_q <= cfg_down;
            end
        end
    end

    always_comb begin
        st_d       = st_q;
        count_d    = count;
        rep_d      = rep_left;
        run_mod_d  = run_mod_q;
        run_down_d = run_down_q;
        case (st_q)
            IDLE: begin
                if (start) begin
                    st_d       = RUN;
                    count_d    = idle_first_v;
                    rep_d      = reps_q;
                    run_mod_d  = mod_q;
                    run_down_d = down_q;
                end
            end
            RUN: begin
                if (stop) begin
                    st_d    = IDLE;
                    count_d = first_v;
                    rep_d   = '0;
                end else if (pause) begin
                    st_d = PAUSE;
                end else if (count == term_v) begin
                    count_d = first_v;
                    if (rep_left == REP_W'(1)) begin
                        st_d  = DONE;
                        rep_d = '0;
                    end else if (rep_left != '0) begin
                        rep_d = rep_left - REP_W'(1);
                    end
                end else if (run_down_q) begin
                    count_d = count - WIDTH'(1);
                end else begin
                    count_d = count + WIDTH'(1);
                end
            end
            PAUSE: begin
                if (stop) begin
                    st_d    = IDLE;
                    count_d = first_v;
                    rep_d   = '0;
                end else if (!pause) begin
                    st_d = RUN;
                end
            end
            DONE: begin
                st_d = IDLE;
            end
            default: begin
                st_d = IDLE;
            end
        endcase
    end

    assign cfg_ready = (st_q == IDLE);
    assign tc        = (st_q == RUN) && (count == term_v);
    assign done      = (st_q == DONE);
    assign busy      = (st_q == RUN) || (st_q == PAUSE);
    assign state     = st_q;

endmodule
